// File: rtl/alu_acc_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_acc_ctrl_if
//  Description : Bundle of the command handshake, the ALU drive/return bus
//                and the accumulator status outputs of alu_acc_ctrl.
//                The slave modport is the controller; the master modport
//                is whoever issues commands and hosts the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_acc_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    // Command handshake
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_load;
    logic [2:0]       cmd_opc;
    logic [WIDTH-1:0] cmd_operand;
    logic             cmd_cin;
    // ALU drive and return
    logic [2:0]       alu_opc;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_c;
    logic [WIDTH-1:0] alu_w;
    logic             alu_zer;
    logic             alu_neg;
    // Accumulator status
    logic [WIDTH-1:0] acc;
    logic             zer_q;
    logic             neg_q;
    logic             res_valid;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  cmd_valid, cmd_load, cmd_opc, cmd_operand, cmd_cin,
        input  alu_w, alu_zer, alu_neg,
        output cmd_ready,
        output alu_opc, alu_a, alu_b, alu_c,
        output acc, zer_q, neg_q, res_valid, op_count
    );

    modport master (
        output cmd_valid, cmd_load, cmd_opc, cmd_operand, cmd_cin,
        output alu_w, alu_zer, alu_neg,
        input  cmd_ready,
        input  alu_opc, alu_a, alu_b, alu_c,
        input  acc, zer_q, neg_q, res_valid, op_count
    );
endinterface
`default_nettype wire

// File: rtl/alu_acc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_acc_ctrl
//  Description : Accumulator controller around an external combinational
//                16-bit ALU. Accepts one command per IDLE->EXEC->DONE pass,
//                writes the ALU result (or a bypass load value) back into
//                the accumulator and flags, then pulses res_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_acc_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  wire logic      clk,
    input  wire logic      rst,
    alu_acc_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;

    // Command registers: drive the ALU and hold their value between commands
    logic             load_q,    load_d;
    logic [2:0]       opc_q,     opc_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic             cin_q,     cin_d;

    // Result registers
    logic [WIDTH-1:0] acc_q,     acc_d;
    logic             zer_q,     zer_d;
    logic             neg_q,     neg_d;
    logic [CNT_W-1:0] count_q,   count_d;

    logic             w_accept;

    assign w_accept = bus.cmd_valid && (state_q == ST_IDLE);

    // Next-state and datapath-update decode
    always_comb begin
        state_d   = state_q;
        load_d    = load_q;
        opc_d     = opc_q;
        operand_d = operand_q;
        cin_d     = cin_q;
        acc_d     = acc_q;
        zer_d     = zer_q;
        neg_d     = neg_q;
        count_d   = count_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    load_d    = bus.cmd_load;
                    opc_d     = bus.cmd_opc;
                    operand_d = bus.cmd_operand;
                    cin_d     = bus.cmd_cin;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (load_q) begin
                    // Bypass: ALU outputs are ignored, flags derived locally
                    acc_d = operand_q;
                    zer_d = (operand_q == '0);
                    neg_d = operand_q[WIDTH-1];
                end else begin
                    acc_d = bus.alu_w;
                    zer_d = bus.alu_zer;
                    neg_d = bus.alu_neg;
                end
                state_d = ST_EXEC == state_q ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                count_d = count_q + CNT_W'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and register update; reset overrides any in-flight command
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            load_q    <= 1'b0;
            opc_q     <= 3'd0;
            operand_q <= '0;
            cin_q     <= 1'b0;
            acc_q     <= '0;
            zer_q     <= 1'b1;
            neg_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            load_q    <= load_d;
            opc_q     <= opc_d;
            operand_q <= operand_d;
            cin_q     <= cin_d;
            acc_q     <= acc_d;
            zer_q     <= zer_d;
            neg_q     <= neg_d;
            count_q   <= count_d;
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.res_valid = (state_q == ST_DONE);
    assign bus.alu_opc   = opc_q;
    assign bus.alu_a     = acc_q;
    assign bus.alu_b     = operand_q;
    assign bus.alu_c     = cin_q;
    assign bus.acc       = acc_q;
    assign bus.zer_q     = zer_q;
    assign bus.neg_q     = neg_q;
    assign bus.op_count  = count_q;

endmodule
`default_nettype wire
